// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM timer sequencer and its prescaler.
package pwm_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 16;
  localparam int unsigned PRESC_W_DEFAULT = 8;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  // Bit positions inside the functions word consumed by the generator.
  localparam int unsigned FUNC_ALIGN_RIGHT = 0;
  localparam int unsigned FUNC_UNALIGNED   = 1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider for the timer: tick is high for one clock out of every div+1 while enabled.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRESC_W = PRESC_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_timer_ctrl.sv
// PWM sequencer: prescaled up/down time base, double-buffered configuration and status pulses.
module pwm_timer_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned PRESC_W = PRESC_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_en,
  input  logic               cfg_dir,
  input  logic [PRESC_W-1:0] cfg_prescale,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_compare1,
  input  logic [CNT_W-1:0]   cfg_compare2,
  input  logic [7:0]         cfg_functions,
  input  logic               cfg_upd_req,
  input  logic               cfg_cnt_reset,
  output logic               pwm_en,
  output logic [CNT_W-1:0]   count_val,
  output logic [CNT_W-1:0]   period,
  output logic [CNT_W-1:0]   compare1,
  output logic [CNT_W-1:0]   compare2,
  output logic [7:0]         functions,
  output logic               upd_pending,
  output logic               period_evt,
  output logic               upd_done
);

  state_e             state_q, state_d;
  logic               pwm_en_q, pwm_en_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pending_q, pending_d;
  logic               evt_q, evt_d;
  logic               done_q;
  logic               load;

  logic [CNT_W-1:0]   period_q, cmp1_q, cmp2_q;
  logic [7:0]         func_q;
  logic               dir_q;
  logic [PRESC_W-1:0] presc_q;

  logic               tick;
  logic               presc_en;
  logic               upd_now;
  logic               next_dir;
  logic [CNT_W-1:0]   next_period;
  logic [CNT_W-1:0]   start_val;
  logic               wrap;

  assign presc_en = (state_q == StRun) && cfg_en;

  pwm_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (presc_en),
    .clear  (cfg_cnt_reset),
    .div    (presc_q),
    .tick   (tick)
  );

  // Start value after a wrap or restart reflects the shadows as they will be after this edge.
  assign upd_now     = pending_q | cfg_upd_req;
  assign next_dir    = upd_now ? cfg_dir : dir_q;
  assign next_period = upd_now ? cfg_period : period_q;
  assign start_val   = (next_dir == DIR_DOWN) ? next_period : '0;
  assign wrap        = (dir_q == DIR_UP) ? (count_q == period_q) : (count_q == '0);

  always_comb begin
    state_d   = state_q;
    pwm_en_d  = pwm_en_q;
    count_d   = count_q;
    pending_d = pending_q;
    evt_d     = 1'b0;
    load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        pwm_en_d = 1'b0;
        count_d  = '0;
        if (cfg_en) begin
          state_d  = StRun;
          pwm_en_d = 1'b1;
          load     = 1'b1;
          count_d  = (cfg_dir == DIR_DOWN) ? cfg_period : '0;
        end else if (cfg_upd_req) begin
          load = 1'b1;
        end
      end
      StRun: begin
        if (!cfg_en) begin
          state_d   = StIdle;
          pwm_en_d  = 1'b0;
          count_d   = '0;
          pending_d = upd_now;
        end else if (cfg_cnt_reset) begin
          // Restart overrides any coincident wrap, so no period_evt here.
          load    = upd_now;
          count_d = start_val;
        end else begin
          pending_d = upd_now;
          if (tick) begin
            if (wrap) begin
              evt_d   = 1'b1;
              load    = upd_now;
              count_d = start_val;
            end else if (dir_q == DIR_DOWN) begin
              count_d = count_q - CNT_W'(1);
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pwm_en_q  <= 1'b0;
      count_q   <= '0;
      pending_q <= 1'b0;
      evt_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwm_en_q  <= pwm_en_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      evt_q     <= evt_d;
      done_q    <= load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      cmp1_q   <= '0;
      cmp2_q   <= '0;
      func_q   <= '0;
      dir_q    <= 1'b0;
      presc_q  <= '0;
    end else if (load) begin
      period_q <= cfg_period;
      cmp1_q   <= cfg_compare1;
      cmp2_q   <= cfg_compare2;
      func_q   <= cfg_functions;
      dir_q    <= cfg_dir;
      presc_q  <= cfg_prescale;
    end
  end

  assign pwm_en      = pwm_en_q;
  assign count_val   = count_q;
  assign period      = period_q;
  assign compare1    = cmp1_q;
  assign compare2    = cmp2_q;
  assign functions   = func_q;
  assign upd_pending = pending_q;
  assign period_evt  = evt_q;
  assign upd_done    = done_q;

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Scoreboard bench for pwm_timer_ctrl: per-cycle expectations queued at drive time.
module tb_pwm_timer_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_en;
  logic        cfg_dir;
  logic [7:0]  cfg_prescale;
  logic [15:0] cfg_period;
  logic [15:0] cfg_compare1;
  logic [15:0] cfg_compare2;
  logic [7:0]  cfg_functions;
  logic        cfg_upd_req;
  logic        cfg_cnt_reset;
  logic        pwm_en;
  logic [15:0] count_val;
  logic [15:0] period;
  logic [15:0] compare1;
  logic [15:0] compare2;
  logic [7:0]  functions;
  logic        upd_pending;
  logic        period_evt;
  logic        upd_done;

  pwm_timer_ctrl #(
    .CNT_W   (16),
    .PRESC_W (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_en        (cfg_en),
    .cfg_dir       (cfg_dir),
    .cfg_prescale  (cfg_prescale),
    .cfg_period    (cfg_period),
    .cfg_compare1  (cfg_compare1),
    .cfg_compare2  (cfg_compare2),
    .cfg_functions (cfg_functions),
    .cfg_upd_req   (cfg_upd_req),
    .cfg_cnt_reset (cfg_cnt_reset),
    .pwm_en        (pwm_en),
    .count_val     (count_val),
    .period        (period),
    .compare1      (compare1),
    .compare2      (compare2),
    .functions     (functions),
    .upd_pending   (upd_pending),
    .period_evt    (period_evt),
    .upd_done      (upd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pwm;
    logic [15:0] cnt;
    logic        evt;
    logic        done;
    logic        pend;
  } exp_t;

  exp_t  sb_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc_no = 0;
  string phase  = "reset";

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s @cyc %0d: got %0h expected %0h", phase, tag, cyc_no, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic p, input int c, input logic e, input logic d,
                              input logic pe);
    exp_t r;
    r.pwm  = p;
    r.cnt  = 16'(c);
    r.evt  = e;
    r.done = d;
    r.pend = pe;
    return r;
  endfunction

  // Queue the expected post-edge state, advance one clock, then compare against the DUT.
  task automatic cyc(input exp_t e);
    exp_t g;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc_no++;
    g = sb_q.pop_front();
    check_val("pwm_en",      32'(pwm_en),      32'(g.pwm));
    check_val("count_val",   32'(count_val),   32'(g.cnt));
    check_val("period_evt",  32'(period_evt),  32'(g.evt));
    check_val("upd_done",    32'(upd_done),    32'(g.done));
    check_val("upd_pending", 32'(upd_pending), 32'(g.pend));
  endtask

  task automatic go_idle();
    cfg_en = 1'b0;
    cyc(mk(0, 0, 0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    cfg_en        = 1'b0;
    cfg_dir       = 1'b0;
    cfg_prescale  = '0;
    cfg_period    = '0;
    cfg_compare1  = '0;
    cfg_compare2  = '0;
    cfg_functions = '0;
    cfg_upd_req   = 1'b0;
    cfg_cnt_reset = 1'b0;
    #12;
    check_val("rst pwm_en",    32'(pwm_en),      0);
    check_val("rst count",     32'(count_val),   0);
    check_val("rst period",    32'(period),      0);
    check_val("rst functions", 32'(functions),   0);
    check_val("rst pending",   32'(upd_pending), 0);
    check_val("rst evt",       32'(period_evt),  0);
    check_val("rst done",      32'(upd_done),    0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic up count, period 4.
    phase         = "up";
    cfg_period    = 16'd4;
    cfg_prescale  = 8'd0;
    cfg_dir       = 1'b0;
    cfg_compare1  = 16'h0001;
    cfg_compare2  = 16'h0003;
    cfg_functions = 8'hA5;
    cfg_en        = 1'b1;
    cyc(mk(1, 0, 0, 1, 0));
    for (int k = 1; k <= 10; k++) cyc(mk(1, k % 5, (k % 5) == 0, 0, 0));
    check_val("period",    32'(period),    4);
    check_val("compare1",  32'(compare1),  1);
    check_val("compare2",  32'(compare2),  3);
    check_val("functions", 32'(functions), 32'h A5);
    // Unrequested writes must not reach the shadows.
    cfg_period = 16'd7;
    cyc(mk(1, 1, 0, 0, 0));
    check_val("period held", 32'(period), 4);
    go_idle();
    check_val("period idle", 32'(period), 4);

    // Prescale 2, period 2.
    phase        = "presc";
    cfg_period   = 16'd2;
    cfg_prescale = 8'd2;
    cfg_en       = 1'b1;
    cyc(mk(1, 0, 0, 1, 0));
    for (int k = 1; k <= 18; k++) cyc(mk(1, (k / 3) % 3, (k % 9) == 0, 0, 0));
    go_idle();

    // Buffered period update applied at the wrap.
    phase        = "upd";
    cfg_period   = 16'd9;
    cfg_prescale = 8'd0;
    cfg_en       = 1'b1;
    cyc(mk(1, 0, 0, 1, 0));
    for (int k = 1; k <= 2; k++) cyc(mk(1, k, 0, 0, 0));
    cfg_period  = 16'd3;
    cfg_upd_req = 1'b1;
    cyc(mk(1, 3, 0, 0, 1));
    cfg_upd_req = 1'b0;
    for (int k = 4; k <= 9; k++) cyc(mk(1, k, 0, 0, 1));
    check_val("period before wrap", 32'(period), 9);
    cyc(mk(1, 0, 1, 1, 0));
    check_val("period after wrap", 32'(period), 3);
    for (int k = 1; k <= 8; k++) cyc(mk(1, k % 4, (k % 4) == 0, 0, 0));
    go_idle();

    // Down mode, then degenerate period 0.
    phase      = "down";
    cfg_dir    = 1'b1;
    cfg_period = 16'd3;
    cfg_en     = 1'b1;
    cyc(mk(1, 3, 0, 1, 0));
    for (int k = 1; k <= 8; k++) cyc(mk(1, 3 - (k % 4), (k % 4) == 0, 0, 0));
    go_idle();
    phase      = "period0";
    cfg_period = 16'd0;
    cfg_en     = 1'b1;
    cyc(mk(1, 0, 0, 1, 0));
    for (int k = 1; k <= 4; k++) cyc(mk(1, 0, 1, 0, 0));
    go_idle();

    // Counter restart with a pending update, coincident with a wrap.
    phase      = "cntrst";
    cfg_dir    = 1'b0;
    cfg_period = 16'd4;
    cfg_en     = 1'b1;
    cyc(mk(1, 0, 0, 1, 0));
    cyc(mk(1, 1, 0, 0, 0));
    cfg_period  = 16'd2;
    cfg_upd_req = 1'b1;
    cyc(mk(1, 2, 0, 0, 1));
    cfg_upd_req = 1'b0;
    cyc(mk(1, 3, 0, 0, 1));
    cyc(mk(1, 4, 0, 0, 1));
    cfg_cnt_reset = 1'b1;
    cyc(mk(1, 0, 0, 1, 0));
    cfg_cnt_reset = 1'b0;
    cyc(mk(1, 1, 0, 0, 0));
    cyc(mk(1, 2, 0, 0, 0));
    cyc(mk(1, 0, 1, 0, 0));
    cyc(mk(1, 1, 0, 0, 0));
    check_val("period restart", 32'(period), 2);

    // Asynchronous reset while an update is pending.
    phase       = "async";
    cfg_upd_req = 1'b1;
    cyc(mk(1, 2, 0, 0, 1));
    cfg_upd_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("pwm_en",    32'(pwm_en),      0);
    check_val("count_val", 32'(count_val),   0);
    check_val("period",    32'(period),      0);
    check_val("compare1",  32'(compare1),    0);
    check_val("compare2",  32'(compare2),    0);
    check_val("functions", 32'(functions),   0);
    check_val("pending",   32'(upd_pending), 0);
    check_val("evt",       32'(period_evt),  0);
    check_val("done",      32'(upd_done),    0);
    cfg_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(mk(0, 0, 0, 0, 0));

    // Update request while idle loads shadows directly.
    phase       = "idle_upd";
    cfg_period  = 16'd6;
    cfg_upd_req = 1'b1;
    cyc(mk(0, 0, 0, 1, 0));
    cfg_upd_req = 1'b0;
    check_val("period", 32'(period), 6);
    cyc(mk(0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
